multicore_bus_arbiter: RTL

- Parametrised bus controller and coherence arbiter between NCORES instruction/data cache pairs and a single RAM port.
- Round-robin arbitration per request class, with multi-word block writeback and snoop broadcast to all other data caches.
- Cache-to-cache transfer with concurrent memory update when a snooper holds the line dirty.
- Sits between the per-core cache controllers and the memory controller; generalises the two-core bus controller to N cores and a configurable block size.

---
 rtl/multicore_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicore_bus_arbiter.sv
// multicore_bus_arbiter: bus controller and coherence arbiter that connects
// NCORES instruction/data cache pairs to a single RAM port.
// Round-robin arbitration per request class (writeback > coherent miss >
// ifetch), snoop broadcast, and cache-to-cache transfer that updates RAM
// in the same cycles.
// Optional feature macro: BUS_STATS_EN adds the stat_c2c / stat_wb counters.
module multicore_bus_arbiter #(
  parameter int NCORES = 2,
  parameter int WORDS  = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCORES-1:0]    iREN,
  input  logic [NCORES*AW-1:0] iaddr,
  output logic [NCORES-1:0]    iwait,
  output logic [NCORES*DW-1:0] iload,
  input  logic [NCORES-1:0]    dREN,
  input  logic [NCORES-1:0]    dWEN,
  input  logic [NCORES*AW-1:0] daddr,
  input  logic [NCORES*DW-1:0] dstore,
  output logic [NCORES-1:0]    dwait,
  output logic [NCORES*DW-1:0] dload,
  input  logic [NCORES-1:0]    cctrans,
  input  logic [NCORES-1:0]    ccwrite,
  output logic [NCORES-1:0]    ccwait,
  output logic [NCORES-1:0]    ccinv,
  output logic [NCORES*AW-1:0] ccsnoopaddr,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [AW-1:0]        ramaddr,
  output logic [DW-1:0]        ramstore,
  input  logic [DW-1:0]        ramload,
  input  logic [1:0]           ramstate
`ifdef BUS_STATS_EN
  ,
  output logic [31:0]          stat_c2c,
  output logic [31:0]          stat_wb
`endif
);

  localparam int CW  = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WB     = 3'd1,
    S_SNOOP  = 3'd2,
    S_LD     = 3'd3,
    S_C2C    = 3'd4,
    S_IFETCH = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     g_q, g_d;
  logic [CW-1:0]     s_q, s_d;
  logic [WCW-1:0]    cnt_q, cnt_d;
  logic [NCORES-1:0] ack_q, ack_d;
  logic [NCORES-1:0] dirty_q, dirty_d;

  logic              acc_s;
  logic              last_s;
  logic              done_s;
  logic [NCORES-1:0] own_s;
  logic [NCORES-1:0] miss_req_s;
  logic [NCORES-1:0] ack_now_s;
  logic [NCORES-1:0] dirty_now_s;

  // First requester at or after ptr, wrapping around the core ring.
  function automatic logic [CW-1:0] rr_pick(input logic [NCORES-1:0] req,
                                            input logic [CW-1:0] ptr);
    int idx;
    rr_pick = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NCORES;
      if (req[idx]) rr_pick = CW'(idx);
    end
  endfunction

  // Lowest set bit index; used to choose the supplying snooper.
  function automatic logic [CW-1:0] lowest(input logic [NCORES-1:0] v);
    lowest = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      if (v[k]) lowest = CW'(k);
    end
  endfunction

  // ERROR and BUSY both stall; only ACCESS moves a word.
  assign acc_s       = (ramstate == RAM_ACCESS);
  assign last_s      = (cnt_q == WCW'(WORDS - 1));
  assign own_s       = NCORES'(1) << g_q;
  assign miss_req_s  = cctrans & dREN;
  assign ack_now_s   = ack_q | (cctrans & ~own_s) | own_s;
  assign dirty_now_s = dirty_q | (cctrans & ccwrite & ~own_s);

  // Next-state, bookkeeping and all bus outputs for the current phase.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    g_d         = g_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    ack_d       = ack_q;
    dirty_d     = dirty_q;
    done_s      = 1'b0;
    iwait       = '1;
    iload       = '0;
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state_q)
      S_IDLE: begin
        if (|dWEN) begin
          g_d     = rr_pick(dWEN, rr_q);
          state_d = S_WB;
        end else if (|miss_req_s) begin
          g_d     = rr_pick(miss_req_s, rr_q);
          state_d = S_SNOOP;
        end else if (|iREN) begin
          g_d     = rr_pick(iREN, rr_q);
          state_d = S_IFETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        ramWEN      = 1'b1;
        ramaddr     = daddr[g_q*AW +: AW];
        ramstore    = dstore[g_q*DW +: DW];
        dwait[g_q]  = ~acc_s;
        ccwait      = ~own_s;
        done_s      = acc_s & last_s;
      end
      S_SNOOP: begin
        ccwait = ~own_s;
        ccinv  = ~own_s & {NCORES{ccwrite[g_q]}};
        for (int k = 0; k < NCORES; k++) begin
          if (k != int'(g_q)) ccsnoopaddr[k*AW +: AW] = daddr[g_q*AW +: AW];
        end
        ack_d   = ack_now_s;
        dirty_d = dirty_now_s;
        if (&ack_now_s) begin
          if (|dirty_now_s) begin
            s_d     = lowest(dirty_now_s);
            state_d = S_C2C;
          end else begin
            state_d = S_LD;
          end
        end else begin
          state_d = S_SNOOP;
        end
      end
      S_LD: begin
        ramREN                = 1'b1;
        ramaddr               = daddr[g_q*AW +: AW];
        dload[g_q*DW +: DW]   = ramload;
        dwait[g_q]            = ~acc_s;
        ccwait                = ~own_s;
        done_s                = acc_s & last_s;
      end
      S_C2C: begin
        ramWEN                = 1'b1;
        ramaddr               = daddr[s_q*AW +: AW];
        ramstore              = dstore[s_q*DW +: DW];
        dload[g_q*DW +: DW]   = dstore[s_q*DW +: DW];
        dwait[g_q]            = ~acc_s;
        dwait[s_q]            = ~acc_s;
        done_s                = acc_s & last_s;
      end
      S_IFETCH: begin
        ramREN                = 1'b1;
        ramaddr               = iaddr[g_q*AW +: AW];
        iload[g_q*DW +: DW]   = ramload;
        iwait[g_q]            = ~acc_s;
        done_s                = acc_s;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (done_s) begin
      state_d = S_IDLE;
      rr_d    = (g_q == CW'(NCORES - 1)) ? '0 : g_q + 1'b1;
      cnt_d   = '0;
      ack_d   = '0;
      dirty_d = '0;
    end else if (acc_s && (state_q == S_WB || state_q == S_LD || state_q == S_C2C)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // Controller state registers; reset abandons any partial block.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dirty_q <= dirty_d;
    end
  end

`ifdef BUS_STATS_EN
  logic [31:0] stat_c2c_q, stat_wb_q;

  // Saturating counts of completed C2C and writeback transactions.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_c2c_q <= 32'd0;
      stat_wb_q  <= 32'd0;
    end else begin
      if (done_s && state_q == S_C2C && stat_c2c_q != 32'hFFFF_FFFF)
        stat_c2c_q <= stat_c2c_q + 32'd1;
      if (done_s && state_q == S_WB && stat_wb_q != 32'hFFFF_FFFF)
        stat_wb_q <= stat_wb_q + 32'd1;
    end
  end

  assign stat_c2c = stat_c2c_q;
  assign stat_wb  = stat_wb_q;
`endif

endmodule
